// File: rtl/cgra_pkt_rx_dma_if.sv
// Handshake bundle between the RX DMA engine, its SRAM read port and the CGRA receive port.
interface cgra_pkt_rx_dma_if #(
  parameter int ADDR_W = 64,
  parameter int PKT_W  = 185
);
  logic              mem_req_val;
  logic              mem_req_rdy;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_val;
  logic [63:0]       mem_rsp_data;
  logic              send_val;
  logic              send_rdy;
  logic [PKT_W-1:0]  send_msg;

  modport master (
    output mem_req_val, mem_req_addr, send_val, send_msg,
    input  mem_req_rdy, mem_rsp_val, mem_rsp_data, send_rdy
  );

  modport slave (
    input  mem_req_val, mem_req_addr, send_val, send_msg,
    output mem_req_rdy, mem_rsp_val, mem_rsp_data, send_rdy
  );
endinterface

// File: rtl/cgra_pkt_rx_dma.sv
// Memory-to-CGRA DMA read engine: fetches 24-byte containers as 64-bit beats,
// reassembles them into CGRA packets and streams them out through a small FIFO.
module cgra_pkt_rx_dma #(
  parameter int ADDR_W        = 64,
  parameter int LEN_W         = 32,
  parameter int PKT_W         = 185,
  parameter int BEATS_PER_PKT = 3,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_start,
  output logic              stat_busy,
  output logic              stat_done,
  cgra_pkt_rx_dma_if.master bus
);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
  localparam int PART_W = 64 * (BEATS_PER_PKT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  ALMOST_CNT = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS_PER_PKT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_fetched;
  logic [LEN_W-1:0]   w_fetched_inc;
  logic [BEAT_W-1:0]  r_beat;
  logic               r_pending;
  logic               r_done;
  logic [PART_W-1:0]  r_cont;

  logic [PKT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  logic w_start;
  logic w_req_fire;
  logic w_rsp_fire;
  logic w_push;
  logic w_pop;
  logic w_finish;
  logic w_slot_free;
  logic w_slot_after_push;
  logic [PTR_W-1:0] w_wptr_inc;
  logic [PTR_W-1:0] w_rptr_inc;

  assign w_pop             = (r_count != '0) && bus.send_rdy;
  assign w_fetched_inc     = r_fetched + LEN_W'(1);
  assign w_slot_free       = (r_count != FULL_CNT) || w_pop;
  assign w_slot_after_push = (r_count != ALMOST_CNT) || w_pop;
  assign w_wptr_inc        = (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
  assign w_rptr_inc        = (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
  assign w_finish          = (r_state == S_DRAIN) && (w_state_next == S_IDLE);

  assign bus.mem_req_val  = (r_state == S_REQ);
  assign bus.mem_req_addr = r_addr;
  assign bus.send_val     = (r_count != '0);
  assign bus.send_msg     = r_mem[r_rptr];
  assign stat_busy        = (r_state != S_IDLE);
  assign stat_done        = r_done;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_req_fire   = 1'b0;
    w_rsp_fire   = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_start = 1'b1;
          if (cfg_len != '0) w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_req_rdy) begin
          w_req_fire   = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Without an outstanding request we are parked waiting for a FIFO slot.
        if (!r_pending) begin
          if (w_slot_free) w_state_next = S_REQ;
        end else if (bus.mem_rsp_val) begin
          w_rsp_fire = 1'b1;
          if (r_beat != LAST_BEAT) begin
            w_state_next = S_REQ;
          end else begin
            w_push = 1'b1;
            if (w_fetched_inc == r_len)  w_state_next = S_DRAIN;
            else if (w_slot_after_push)  w_state_next = S_REQ;
          end
        end
      end
      S_DRAIN: begin
        if ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop)) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_fetched <= '0;
      r_beat    <= '0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_addr    <= cfg_src & ~ADDR_W'(7);
        r_len     <= cfg_len;
        r_fetched <= '0;
        r_beat    <= '0;
        r_done    <= (cfg_len == '0);
      end
      if (w_req_fire) r_pending <= 1'b1;
      if (w_rsp_fire) begin
        r_pending <= 1'b0;
        r_addr    <= r_addr + ADDR_W'(8);
        r_beat    <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
      end
      if (w_push)   r_fetched <= w_fetched_inc;
      if (w_finish) r_done    <= 1'b1;
    end
  end

  // The final beat goes straight into the FIFO together with the staged ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BEATS_PER_PKT - 1; i++) begin
      if (w_rsp_fire && (r_beat == BEAT_W'(i))) r_cont[64*i +: 64] <= bus.mem_rsp_data;
    end
    if (w_push) r_mem[r_wptr] <= PKT_W'({bus.mem_rsp_data, r_cont});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= w_wptr_inc;
      if (w_pop)  r_rptr <= w_rptr_inc;
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end
endmodule
